// File: rtl/dsp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dsp_ctrl_pkg
// Shared definitions for the DSP-slice MAC sequencer:
//   - OPMODE encodings driven onto the slice post-adder
//   - controller state enum
//   - per-cycle tag carried alongside the slice data pipeline
// ----------------------------------------------------------------------------
package dsp_ctrl_pkg;

    // Z=0, X=M, add: the first product of a job overwrites P.
    localparam logic [7:0] OPMODE_LOAD_M = 8'h01;
    // Z=P, X=M, add: later products (and zero bubbles) accumulate into P.
    localparam logic [7:0] OPMODE_ACC_M  = 8'h09;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // v: a real operand pair entered the slice this cycle (0 = bubble)
    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } tag_t;

    // Only a valid first-of-job tag loads P; everything else accumulates.
    function automatic logic [7:0] opmode_for(input tag_t t);
        return (t.v && t.first) ? OPMODE_LOAD_M : OPMODE_ACC_M;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// ----------------------------------------------------------------------------
// dsp_tag_pipe
// LAT-deep shift register of tags that tracks the DSP slice data pipeline.
// It advances only when the slice clock enable is high, so tags stay aligned
// with the A0/A1/M/P stages they describe.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_ce            shift enable (same as slice CE)
//   i_clr           synchronous clear of every stage
//   i_tag           tag entering the pipe this cycle
//   o_tap_lm1       tag delayed LAT-1 cycles (lines up with the P update)
//   o_tap_lat       tag delayed LAT cycles (lines up with the new P value)
// ----------------------------------------------------------------------------
module dsp_tag_pipe
    import dsp_ctrl_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ce,
    input  logic i_clr,
    input  tag_t i_tag,
    output tag_t o_tap_lm1,
    output tag_t o_tap_lat
);

    // w_chain[k] is the tag delayed by k cycles; w_chain[0] is the input.
    tag_t [LAT:0] w_chain;

    assign w_chain[0] = i_tag;

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            tag_t r_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_q <= '0;
                end else if (i_clr) begin
                    r_q <= '0;
                end else if (i_ce) begin
                    r_q <= w_chain[gi];
                end
            end

            assign w_chain[gi+1] = r_q;
        end
    endgenerate

    assign o_tap_lm1 = w_chain[LAT-1];
    assign o_tap_lat = w_chain[LAT];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// ----------------------------------------------------------------------------
// dsp_mac_sequencer
// Job-level controller that runs one DSP48-style slice (A0, A1/B1, M, P) as a
// multiply-accumulate engine. A job of i_len operand pairs is streamed into
// the slice; the first product loads P, the rest accumulate, and the final P
// is presented on o_result with a valid/ready handshake.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_start, i_len               job request and pair count (sampled in IDLE)
//   i_abort                      synchronous job cancel
//   o_busy                       high whenever not IDLE
//   i_in_valid, o_in_ready       operand-pair handshake
//   i_in_a, i_in_b               operand pair
//   o_dsp_a, o_dsp_b             slice A/B inputs (zero on bubbles)
//   o_dsp_opmode                 slice OPMODE
//   o_dsp_ce, o_dsp_rstp         slice clock enable (all stages) and P reset
//   i_dsp_p                      slice P output
//   o_result, o_result_valid,
//   i_result_ready               result handshake
// ----------------------------------------------------------------------------
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_abort,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [17:0]      i_in_a,
    input  logic [17:0]      i_in_b,
    output logic [17:0]      o_dsp_a,
    output logic [17:0]      o_dsp_b,
    output logic [7:0]       o_dsp_opmode,
    output logic             o_dsp_ce,
    output logic             o_dsp_rstp,
    input  logic [47:0]      i_dsp_p,
    output logic [47:0]      o_result,
    output logic             o_result_valid,
    input  logic             i_result_ready
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued;
    logic [47:0]      r_result;
    logic             r_result_valid;
    logic             r_dsp_rstp;

    logic w_abort;
    logic w_launch;
    logic w_in_ready;
    logic w_xfer;
    logic w_last;
    logic w_capture;
    logic w_ce;
    tag_t w_tag_in;
    tag_t w_tap_lm1;
    tag_t w_tap_lat;

    // ABORT has no effect in IDLE, but still suppresses a START there.
    assign w_abort    = i_abort && (r_state != ST_IDLE);
    assign w_launch   = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_in_ready = (r_state == ST_RUN) && (r_issued < r_len);
    assign w_xfer     = w_in_ready && i_in_valid;
    // issued < len guarantees issued+1 cannot wrap, even for len = 2^LEN_W-1.
    assign w_last     = w_xfer && ((r_issued + LEN_ONE) == r_len);
    assign w_ce       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    // The last product is visible on P exactly when its tag reaches depth LAT.
    assign w_capture  = (r_state == ST_DRAIN) && w_tap_lat.v && w_tap_lat.last;

    assign w_tag_in = '{v: w_xfer, first: w_xfer && (r_issued == '0), last: w_last};

    dsp_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ce      (w_ce),
        .i_clr     (w_abort),
        .i_tag     (w_tag_in),
        .o_tap_lm1 (w_tap_lm1),
        .o_tap_lat (w_tap_lat)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_launch) w_state_next = (i_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_capture) w_state_next = ST_DONE;
            ST_DONE:  if (r_result_valid && i_result_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_issued       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_dsp_rstp     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dsp_rstp <= w_abort;

            if (w_launch) begin
                r_len    <= i_len;
                r_issued <= '0;
            end else if (w_xfer) begin
                r_issued <= r_issued + LEN_ONE;
            end

            if (w_launch && (i_len == '0)) begin
                r_result <= '0;
            end else if (w_capture && !w_abort) begin
                r_result <= i_dsp_p;
            end

            // Valid rises on capture; an empty job enters DONE with valid low
            // and raises it one cycle later. It falls on the handshake.
            if (w_abort) begin
                r_result_valid <= 1'b0;
            end else if (w_capture) begin
                r_result_valid <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_result_valid <= !(r_result_valid && i_result_ready);
            end
        end
    end

    assign o_busy         = (r_state != ST_IDLE);
    assign o_in_ready     = w_in_ready;
    assign o_dsp_a        = w_xfer ? i_in_a : '0;
    assign o_dsp_b        = w_xfer ? i_in_b : '0;
    assign o_dsp_opmode   = opmode_for(w_tap_lm1);
    assign o_dsp_ce       = w_ce;
    assign o_dsp_rstp     = r_dsp_rstp;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dsp_mac_sequencer
// Directed bench for dsp_mac_sequencer driving a behavioural 4-stage DSP slice
// (A0, A1/B1, M, P) whose P update decodes OPMODE bit 3 (Z=P) and bit 0 (X=M).
// ----------------------------------------------------------------------------
module tb_dsp_mac_sequencer;

    localparam int LAT   = 4;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [LEN_W-1:0] i_len = '0;
    logic             i_abort = 1'b0;
    logic             i_in_valid = 1'b0;
    logic [17:0]      i_in_a = '0;
    logic [17:0]      i_in_b = '0;
    logic             i_result_ready = 1'b0;
    logic             o_busy, o_in_ready, o_dsp_ce, o_dsp_rstp, o_result_valid;
    logic [17:0]      o_dsp_a, o_dsp_b;
    logic [7:0]       o_dsp_opmode;
    logic [47:0]      o_result;
    logic [47:0]      dsp_p;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mac_sequencer #(.LAT(LAT), .LEN_W(LEN_W)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_len          (i_len),
        .i_abort        (i_abort),
        .o_busy         (o_busy),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_in_a         (i_in_a),
        .i_in_b         (i_in_b),
        .o_dsp_a        (o_dsp_a),
        .o_dsp_b        (o_dsp_b),
        .o_dsp_opmode   (o_dsp_opmode),
        .o_dsp_ce       (o_dsp_ce),
        .o_dsp_rstp     (o_dsp_rstp),
        .i_dsp_p        (dsp_p),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready)
    );

    // Behavioural slice; starts with junk that the first product must overwrite.
    logic signed [17:0] s_a0 = 18'sd111, s_b0 = 18'sd222, s_a1 = 18'sd333, s_b1 = 18'sd444;
    logic signed [35:0] s_m  = 36'sd555;
    logic        [47:0] s_p  = 48'h0BAD_0BAD_0BAD;

    always @(posedge clk) begin
        if (o_dsp_rstp) begin
            s_p <= 48'd0;
        end else if (o_dsp_ce) begin
            s_p <= (o_dsp_opmode[3] ? s_p : 48'd0) +
                   (o_dsp_opmode[0] ? {{12{s_m[35]}}, s_m} : 48'd0);
        end
        if (o_dsp_ce) begin
            s_a0 <= o_dsp_a;
            s_b0 <= o_dsp_b;
            s_a1 <= s_a0;
            s_b1 <= s_b0;
            s_m  <= 36'(s_a1) * 36'(s_b1);
        end
    end
    assign dsp_p = s_p;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [17:0] op_a [4];
    logic [17:0] op_b [4];
    logic [7:0]  op_log [$];
    bit          ce_seen;
    bit          rv_seen;
    int          rstp_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    // Advance to the next falling edge and record what the DUT shows there.
    task automatic tick();
        @(negedge clk);
        if (o_dsp_ce) begin
            ce_seen = 1'b1;
            op_log.push_back(o_dsp_opmode);
        end
        if (o_dsp_rstp) rstp_cnt++;
        if (o_result_valid) rv_seen = 1'b1;
    endtask

    task automatic set_ops(input logic [17:0] a0, a1, a2, a3, b0, b1, b2, b3);
        op_a[0] = a0; op_a[1] = a1; op_a[2] = a2; op_a[3] = a3;
        op_b[0] = b0; op_b[1] = b1; op_b[2] = b2; op_b[3] = b3;
    endtask

    // Issue START in cycle s, stream the pairs (optionally pausing gap_n cycles
    // once gap_at pairs have gone), and return the cycle RESULT_VALID is seen.
    task automatic run_job(input int len, input int gap_at, input int gap_n, output int lat);
        int sent;
        int gap_left;
        int budget;
        int s;
        sent     = 0;
        gap_left = gap_n;
        budget   = 0;
        op_log.delete();
        ce_seen  = 1'b0;
        s        = cyc;
        i_start  = 1'b1;
        i_len    = 16'(len);
        tick();
        i_start  = 1'b0;
        while (!o_result_valid && budget < 300) begin
            if (sent == gap_at && gap_left > 0) begin
                i_in_valid = 1'b0;
                gap_left--;
                check("ready_in_gap", 64'(o_in_ready), 64'd1);
            end else if (sent < len) begin
                i_in_valid = 1'b1;
                i_in_a     = op_a[sent];
                i_in_b     = op_b[sent];
            end else begin
                i_in_valid = 1'b0;
            end
            #1;
            if (i_in_valid && o_in_ready) begin
                check("dsp_a_pass", 64'(o_dsp_a), 64'(op_a[sent]));
                sent++;
            end
            tick();
            budget++;
        end
        i_in_valid = 1'b0;
        if (!o_result_valid) check("job_timeout", 64'd0, 64'd1);
        lat = cyc - s;
    endtask

    task automatic take_result();
        i_result_ready = 1'b1;
        tick();
        i_result_ready = 1'b0;
        check("valid_drop", 64'(o_result_valid), 64'd0);
        check("idle_after", 64'(o_busy), 64'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_busy"},   64'(o_busy), 64'd0);
        check({pfx, "_ready"},  64'(o_in_ready), 64'd0);
        check({pfx, "_ce"},     64'(o_dsp_ce), 64'd0);
        check({pfx, "_rstp"},   64'(o_dsp_rstp), 64'd0);
        check({pfx, "_opmode"}, 64'(o_dsp_opmode), 64'h09);
        check({pfx, "_rvalid"}, 64'(o_result_valid), 64'd0);
        check({pfx, "_result"}, 64'(o_result), 64'd0);
    endtask

    initial begin
        int lat;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_reset_values("reset");
        i_rst = 1'b0;
        tick();

        // ---------------- LEN=4, no stalls: 5+12+21+32 = 70 ----------------
        set_ops(18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8);
        run_job(4, 99, 0, lat);
        check("t1_result", 64'(o_result), 64'd70);
        check("t1_latency", 64'(lat), 64'd9);
        check("t1_opmode_seq", 64'({op_log[3], op_log[4], op_log[5], op_log[6]}), 64'h01090909);
        take_result();

        // ---------------- same job, 2-cycle gap after pair 2 ----------------
        run_job(4, 2, 2, lat);
        check("t2_result", 64'(o_result), 64'd70);
        check("t2_latency", 64'(lat), 64'd11);
        take_result();

        // ---------------- LEN=0 ----------------
        run_job(0, 99, 0, lat);
        check("t3_result", 64'(o_result), 64'd0);
        check("t3_latency", 64'(lat), 64'd2);
        check("t3_ce_never", 64'(ce_seen), 64'd0);
        take_result();

        // ---------------- back-to-back {3x3} held, then {2x2} ----------------
        set_ops(18'd3, 18'd0, 18'd0, 18'd0, 18'd3, 18'd0, 18'd0, 18'd0);
        run_job(1, 99, 0, lat);
        check("t4a_latency", 64'(lat), 64'd6);
        i_start = 1'b1;
        i_len   = 16'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4a_hold_result", 64'(o_result), 64'd9);
            check("t4a_hold_valid", 64'(o_result_valid), 64'd1);
        end
        i_start = 1'b0;
        take_result();
        set_ops(18'd2, 18'd0, 18'd0, 18'd0, 18'd2, 18'd0, 18'd0, 18'd0);
        run_job(1, 99, 0, lat);
        check("t4b_result", 64'(o_result), 64'd4);
        take_result();

        // ---------------- ABORT after 2 of 4 pairs ----------------
        set_ops(18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8);
        i_start = 1'b1;
        i_len   = 16'd4;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_in_valid = 1'b1;
            i_in_a     = op_a[i];
            i_in_b     = op_b[i];
            tick();
        end
        i_in_valid = 1'b0;
        rstp_cnt   = 0;
        rv_seen    = 1'b0;
        i_abort    = 1'b1;
        tick();
        i_abort    = 1'b0;
        check("t5_idle", 64'(o_busy), 64'd0);
        check("t5_rstp_high", 64'(o_dsp_rstp), 64'd1);
        for (int i = 0; i < 8; i++) tick();
        check("t5_rstp_pulses", 64'(rstp_cnt), 64'd1);
        check("t5_no_valid", 64'(rv_seen), 64'd0);
        set_ops(18'd7, 18'd0, 18'd0, 18'd0, 18'd6, 18'd0, 18'd0, 18'd0);
        run_job(1, 99, 0, lat);
        check("t5_result", 64'(o_result), 64'd42);
        check("t5_latency", 64'(lat), 64'd6);
        take_result();

        // ---------------- asynchronous RST mid-RUN ----------------
        set_ops(18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8);
        i_start = 1'b1;
        i_len   = 16'd4;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_in_valid = 1'b1;
            i_in_a     = op_a[i];
            i_in_b     = op_b[i];
            tick();
        end
        i_in_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check_reset_values("arst");
        tick();
        i_rst = 1'b0;
        tick();
        // 10*3 + 20*4 = 110
        set_ops(18'd10, 18'd20, 18'd0, 18'd0, 18'd3, 18'd4, 18'd0, 18'd0);
        run_job(2, 99, 0, lat);
        check("t6_result", 64'(o_result), 64'd110);
        check("t6_latency", 64'(lat), 64'd7);
        take_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
